// File: rtl/bram_loader.sv
// bram_loader: streams num_words beats into a BRAM write port, addresses 0..target-1.
// Optional excess-data check enabled by defining BRAM_LOADER_OVERRUN_CHK_EN.
module bram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_words,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_ena,
  output logic [ADDR_W-1:0]     bram_addra,
  output logic                  load_done,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  state_t state;
  logic [ADDR_W:0] cnt, target, tgt_next, cnt_inc;
  logic accept;
  assign tgt_next = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign cnt_inc  = cnt + ONE;
  assign s_ready  = state == LOAD;
  assign busy     = state == LOAD;
  assign accept   = s_valid && s_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= '0;
      bram_ena   <= 1'b0;
      bram_din   <= '0;
      bram_addra <= '0;
      load_done  <= 1'b0;
    end else begin
      bram_ena <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        load_done <= 1'b0;
      end else if (state != LOAD) begin
        if (start) begin
          target    <= tgt_next;
          cnt       <= '0;
          load_done <= 1'b0;
          state     <= (tgt_next == '0) ? DONE : LOAD;
        end else if (state == DONE) begin
          load_done <= 1'b1;
        end
      end else if (accept) begin
        // cnt < target <= DEPTH, so the low ADDR_W bits never wrap
        bram_ena   <= 1'b1;
        bram_din   <= s_data;
        bram_addra <= cnt[ADDR_W-1:0];
        cnt        <= cnt_inc;
        if (cnt_inc == target) state <= DONE;
      end
    end
  end
`ifdef BRAM_LOADER_OVERRUN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (clear || (start && state != LOAD)) err <= 1'b0;
    else if (state == DONE && s_valid) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: directed checks of bram_loader with DEPTH=16.
module tb_bram_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0, s_valid = 1'b0;
  logic [4:0] num_words = '0;
  logic [7:0] s_data = '0;
  logic s_ready, bram_ena, load_done, busy, err;
  logic [7:0] bram_din;
  logic [3:0] bram_addra;
  int passed = 0, total = 0, wn = 0, base;
  logic [3:0] waddr [0:255];
  logic [7:0] wdata [0:255];
`ifdef BRAM_LOADER_OVERRUN_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  bram_loader #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .bram_din(bram_din),
    .bram_ena(bram_ena), .bram_addra(bram_addra), .load_done(load_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bram_ena === 1'b1 && wn < 256) begin
    waddr[wn] = bram_addra;
    wdata[wn] = bram_din;
    wn++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] n);
    num_words = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({s_ready, bram_ena, load_done, busy, err} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {s_ready, bram_ena, load_done, busy, err}); else passed++;
    total++; if ({bram_din, bram_addra} !== 12'h0) $display("FAIL reset_bus: got %h expected 000", {bram_din, bram_addra}); else passed++;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    base = wn;
    do_start(5'd4);
    total++; if ({busy, s_ready} !== 2'b11) $display("FAIL b2b_load: got %b expected 11", {busy, s_ready}); else passed++;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'hA1 + i);
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    total++; if ({s_ready, busy, bram_ena, load_done} !== 4'b0010) $display("FAIL b2b_last: got %b expected 0010", {s_ready, busy, bram_ena, load_done}); else passed++;
    total++; if ({bram_addra, bram_din} !== {4'd3, 8'hA4}) $display("FAIL b2b_lastwr: got %h expected 3a4", {bram_addra, bram_din}); else passed++;
    step();
    total++; if ({load_done, bram_ena} !== 2'b10) $display("FAIL b2b_done: got %b expected 10", {load_done, bram_ena}); else passed++;
    total++; if (wn - base !== 4) $display("FAIL b2b_count: got %0d expected 4", wn - base); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (waddr[base+i] !== 4'(i) || wdata[base+i] !== 8'(8'hA1 + i))
        $display("FAIL b2b_wr%0d: got %h/%h expected %h/%h", i, waddr[base+i], wdata[base+i], 4'(i), 8'(8'hA1 + i));
      else passed++;
    end
  endtask

  task automatic test_stall();
    base = wn;
    do_start(5'd3);
    total++; if (load_done !== 1'b0) $display("FAIL stall_restart_done: got %b expected 0", load_done); else passed++;
    for (int i = 0; i < 6; i++) begin
      s_valid = (i % 2 == 0);
      s_data = 8'(8'hB0 + i);
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    total++; if (wn - base !== 3) $display("FAIL stall_count: got %0d expected 3", wn - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (waddr[base+i] !== 4'(i) || wdata[base+i] !== 8'(8'hB0 + 2*i))
        $display("FAIL stall_wr%0d: got %h/%h expected %h/%h", i, waddr[base+i], wdata[base+i], 4'(i), 8'(8'hB0 + 2*i));
      else passed++;
    end
    total++; if (load_done !== 1'b1) $display("FAIL stall_done: got %b expected 1", load_done); else passed++;
  endtask

  task automatic test_overflow();
    base = wn;
    do_start(5'd20);
    for (int i = 0; i < 20; i++) begin
      s_data = 8'(8'h40 + i);
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
    total++; if (wn - base !== 16) $display("FAIL ovf_count: got %0d expected 16", wn - base); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (waddr[base+i] !== 4'(i) || wdata[base+i] !== 8'(8'h40 + i))
        $display("FAIL ovf_wr%0d: got %h/%h expected %h/%h", i, waddr[base+i], wdata[base+i], 4'(i), 8'(8'h40 + i));
      else passed++;
    end
    total++; if ({load_done, s_ready} !== 2'b10) $display("FAIL ovf_done: got %b expected 10", {load_done, s_ready}); else passed++;
    total++; if (err !== ERR_EXP) $display("FAIL ovf_err: got %b expected %b", err, ERR_EXP); else passed++;
  endtask

  task automatic test_zero();
    base = wn;
    do_start(5'd0);
    total++; if ({load_done, busy, s_ready, err} !== 4'b0) $display("FAIL zero_t1: got %b expected 0000", {load_done, busy, s_ready, err}); else passed++;
    step();
    total++; if (load_done !== 1'b1) $display("FAIL zero_done: got %b expected 1", load_done); else passed++;
    step();
    total++; if (wn - base !== 0) $display("FAIL zero_count: got %0d expected 0", wn - base); else passed++;
  endtask

  task automatic test_clear();
    base = wn;
    do_start(5'd5);
    s_valid = 1'b1;
    s_data = 8'hD0;
    step();
    s_data = 8'hD1;
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    total++; if ({busy, s_ready, bram_ena, load_done} !== 4'b0) $display("FAIL clr_state: got %b expected 0000", {busy, s_ready, bram_ena, load_done}); else passed++;
    repeat (3) step();
    s_valid = 1'b0;
    step();
    total++; if (wn - base !== 1 || waddr[base] !== 4'd0 || wdata[base] !== 8'hD0)
      $display("FAIL clr_writes: got n=%0d %h/%h expected n=1 0/d0", wn - base, waddr[base], wdata[base]); else passed++;
    base = wn;
    do_start(5'd2);
    for (int i = 0; i < 2; i++) begin
      s_data = 8'(8'hE0 + i);
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    total++; if (wn - base !== 2) $display("FAIL clr_reload_count: got %0d expected 2", wn - base); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (waddr[base+i] !== 4'(i) || wdata[base+i] !== 8'(8'hE0 + i))
        $display("FAIL clr_reload_wr%0d: got %h/%h expected %h/%h", i, waddr[base+i], wdata[base+i], 4'(i), 8'(8'hE0 + i));
      else passed++;
    end
    total++; if (load_done !== 1'b1) $display("FAIL clr_reload_done: got %b expected 1", load_done); else passed++;
  endtask

  task automatic test_rst_mid();
    base = wn;
    do_start(5'd8);
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'h70 + i);
      s_valid = 1'b1;
      step();
    end
    #2 rst = 1'b1;
    #1;
    total++; if ({s_ready, bram_ena, load_done, busy, err} !== 5'b0) $display("FAIL rst_mid_flags: got %b expected 00000", {s_ready, bram_ena, load_done, busy, err}); else passed++;
    total++; if ({bram_din, bram_addra} !== 12'h0) $display("FAIL rst_mid_bus: got %h expected 000", {bram_din, bram_addra}); else passed++;
    step();
    step();
    rst = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    total++; if (wn - base !== 2) $display("FAIL rst_mid_count: got %0d expected 2", wn - base); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_idle: got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_zero();
    test_clear();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each stream word and BRAM write word.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words in the target BRAM.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): width of the BRAM write address.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-007 SHALL have port num_words, input, ADDR_W+1 bits: word count for the load, sampled on start.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort, which returns the block to IDLE.
REQ-009 SHALL have port s_data, input, DATA_WIDTH bits: stream payload.
REQ-010 SHALL have port s_valid, input, 1 bit: stream payload valid.
REQ-011 SHALL have port s_ready, output, 1 bit: loader accepts a word.
REQ-012 SHALL have port bram_din, output, DATA_WIDTH bits: BRAM write data.
REQ-013 SHALL have port bram_ena, output, 1 bit: BRAM write enable.
REQ-014 SHALL have port bram_addra, output, ADDR_W bits: BRAM write address.
REQ-015 SHALL have port load_done, output, 1 bit: level output; the full load has been committed.
REQ-016 SHALL have port busy, output, 1 bit: high while in LOAD.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for excess stream data.

Function
REQ-018 SHALL implement states IDLE, LOAD and DONE.
REQ-019 IDLE with start=1: SHALL latch min(num_words, DEPTH) as target, zero the word counter, and go to LOAD; if the latched target is 0, SHALL go directly to DONE.
REQ-020 SHALL drive s_ready=1 only in LOAD; a beat transfers when s_valid && s_ready.
REQ-021 For a beat accepted in cycle T, SHALL drive bram_ena=1, bram_din=s_data and bram_addra=counter in cycle T+1 (registered, 1-cycle latency); bram_ena SHALL be 0 in all other cycles.
REQ-022 Each accepted beat SHALL increment the counter; addresses SHALL run 0..target-1 in order with no gaps.
REQ-023 The counter SHALL never exceed target, and bram_addra SHALL never exceed DEPTH-1 (no wrap).
REQ-024 When the beat that brings the counter to target is accepted in cycle T: s_ready SHALL be 0 from T+1, the state SHALL be DONE from T+1, and load_done SHALL rise in T+2, after the final write edge.
REQ-025 load_done SHALL hold high in DONE until start or clear.
REQ-026 start in DONE SHALL behave as start in IDLE and SHALL clear load_done in the same cycle.
REQ-027 start in LOAD SHALL be ignored.
REQ-028 clear in any state SHALL force the next state to IDLE, drop s_ready and load_done next cycle, suppress any pending write, and clear err.
REQ-029 clear and start asserted in the same cycle: clear SHALL win.
REQ-030 busy SHALL equal (state==LOAD).

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, counter=0, target=0, s_ready=0, bram_ena=0, bram_din=0, bram_addra=0, load_done=0, busy=0, err=0.
REQ-032 Reset asserted mid-load SHALL abandon the load; no write SHALL occur after rst rises.

Configuration
REQ-033 Macro BRAM_LOADER_OVERRUN_CHK_EN defined: s_valid=1 in DONE SHALL set err on the next cycle, and err SHALL stay set until start, clear or rst.
REQ-034 Macro BRAM_LOADER_OVERRUN_CHK_EN undefined: err SHALL be constant 0 and no check logic SHALL be built.

Verification
REQ-035 DEPTH=16, start with num_words=4, stream 0xA1..0xA4 back-to-back -> bram_ena high 4 cycles at addresses 0..3 with those data; load_done rises 2 cycles after the 4th acceptance.
REQ-036 num_words=3 with s_valid toggled every other cycle -> exactly 3 writes at addresses 0,1,2; no write in any stall cycle.
REQ-037 num_words=20, DEPTH=16 -> 16 writes (addresses 0..15), then load_done=1 and s_ready=0.
REQ-038 num_words=0 -> no writes; load_done=1 two cycles after start.
REQ-039 clear during beat 2 of 5, with start in the same cycle -> returns to IDLE, no further writes, load_done=0; a new start with num_words=2 loads addresses 0..1.
REQ-040 rst pulse mid-load -> all outputs 0 immediately; with the macro defined, s_valid=1 in DONE -> err=1 until the next start.
